// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and oversampling constants,
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BIT_W      = $clog2(DATA_BITS);

  // True on the last b_tick of a full bit period.
  function automatic logic tick_last(input logic [TICK_W-1:0] cnt);
    return cnt == TICK_W'(OVERSAMPLE - 1);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input,
// with a selectable reset value so an idle-high line stays idle in reset.
module uart_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver oversampling at 16x baud: detects the start bit,
// samples each data bit at mid-bit and reports framing errors on the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  logic              rx_s;
  uart_state_e       state_q;
  logic [TICK_W-1:0] tick_q;
  logic [BIT_W-1:0]  bit_q;
  logic [7:0]        shift_q;
  logic [7:0]        data_q;
  logic              done_q;
  logic              err_q;

  uart_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(rx),
    .q_o(rx_s)
  );

  // Start detection in IDLE ignores b_tick so a start bit arriving right after
  // the mid-stop sample of the previous frame is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            tick_q  <= '0;
          end
        end
        START: begin
          if (b_tick) begin
            if (tick_q == TICK_W'(MID_SAMPLE)) begin
              tick_q <= '0;
              if (!rx_s) begin
                state_q <= DATA;
                bit_q   <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
        end
        DATA: begin
          if (b_tick) begin
            if (tick_last(tick_q)) begin
              tick_q  <= '0;
              shift_q <= {rx_s, shift_q[7:1]};
              if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                state_q <= STOP;
              end else begin
                bit_q <= bit_q + BIT_W'(1);
              end
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
        end
        STOP: begin
          if (b_tick) begin
            if (tick_last(tick_q)) begin
              tick_q  <= '0;
              data_q  <= shift_q;
              err_q   <= ~rx_s;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data      = data_q;
  assign rx_done      = done_q;
  assign rx_frame_err = err_q;
  assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven on rx at 16 b_ticks per bit,
// expected bytes go into a scoreboard that a monitor pops on every rx_done.
module tb_uart_rx;

  localparam int TICK_DIV = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       b_tick;
  logic       rx;
  logic       rx_drv;
  logic       loop_en;
  logic       tx_line;
  logic       tx_req;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_frame_err;
  logic       rx_busy;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_count  = 0;
  logic prev_done   = 1'b0;

  assign rx = loop_en ? tx_line : rx_drv;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .b_tick      (b_tick),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  // Free-running 16x baud strobe, updated on the falling edge.
  initial begin
    b_tick = 1'b0;
    forever begin
      for (int i = 0; i < TICK_DIV; i++) begin
        @(negedge clk);
        b_tick = (i == TICK_DIV - 1);
      end
    end
  end

  // Waits for n b_ticks, then steps just past the edge.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      while (!b_tick) @(posedge clk);
    end
    #1;
  endtask

  // Reference transmitter sharing b_tick, used for loopback.
  initial begin : tx_model
    logic [9:0] fr;
    tx_line = 1'b1;
    forever begin
      @(posedge clk);
      if (tx_req === 1'b1) begin
        #1;
        fr = {1'b1, tx_data, 1'b0};
        for (int b = 0; b < 10; b++) begin
          tx_line = fr[b];
          wait_ticks(16);
        end
        tx_req = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every rx_done must match the oldest expected frame.
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      exp_t e;
      done_count++;
      vectors++;
      if (prev_done === 1'b1) begin
        miscompares++;
        $display("[TB] FAIL done_pulse_width: rx_done high for 2+ clks, required 1");
      end
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_done: got rx_data=%h err=%b, required no rx_done", rx_data, rx_frame_err);
      end else begin
        e = sb.pop_front();
        if ({rx_data, rx_frame_err} !== {e.data, e.err}) begin
          miscompares++;
          $display("[TB] FAIL scoreboard: got rx_data=%h err=%b, required rx_data=%h err=%b",
                   rx_data, rx_frame_err, e.data, e.err);
        end
      end
    end
    prev_done = rx_done;
  end

  // Drives one 8N1 frame; stop_low>0 holds the stop bit low that many ticks,
  // abort_bit>=0 pulses rst in the middle of that data bit and ends the frame.
  task automatic applyStimulus(input logic [7:0] d, input int stop_low, input int abort_bit);
    rx_drv = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      if (i == abort_bit) begin
        wait_ticks(8);
        rst = 1'b1;
        wait_ticks(2);
        rst = 1'b0;
        rx_drv = 1'b1;
        wait_ticks(16);
        return;
      end
      wait_ticks(16);
    end
    if (stop_low > 0) begin
      rx_drv = 1'b0;
      wait_ticks(stop_low);
      rx_drv = 1'b1;
      wait_ticks(16 - stop_low);
    end else begin
      rx_drv = 1'b1;
      wait_ticks(16);
    end
  endtask

  // Bounded wait for the scoreboard to empty; an expired bound is a miscompare.
  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: got %0d frames outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_drv = 1'b1;
    loop_en = 1'b0;
    tx_req = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if (rx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data: got %h, required 00", rx_data); end
    vectors++;
    if (rx_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b, required 0", rx_done); end
    vectors++;
    if (rx_frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b, required 0", rx_frame_err); end
    vectors++;
    if (rx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, required 0", rx_busy); end
    rst = 1'b0;
    wait_ticks(4);
    vectors++;
    if (rx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy: got %b, required 0", rx_busy); end
  endtask

  task automatic test_basic();
    int d0 = done_count;
    sb.push_back({8'h55, 1'b0});
    applyStimulus(8'h55, 0, -1);
    drain("basic");
    vectors++;
    if (done_count - d0 !== 1) begin miscompares++; $display("[TB] FAIL basic_count: got %0d, required 1", done_count - d0); end
    vectors++;
    if (rx_data !== 8'h55) begin miscompares++; $display("[TB] FAIL basic_data: got %h, required 55", rx_data); end
    vectors++;
    if (rx_frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_err: got %b, required 0", rx_frame_err); end
    vectors++;
    if (rx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_busy: got %b, required 0", rx_busy); end
  endtask

  task automatic test_glitch();
    int d0 = done_count;
    logic [7:0] old = rx_data;
    rx_drv = 1'b0;
    wait_ticks(4);
    rx_drv = 1'b1;
    wait_ticks(1);
    vectors++;
    if (rx_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL glitch_busy_start: got %b, required 1", rx_busy); end
    wait_ticks(6);
    vectors++;
    if (rx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_busy_end: got %b, required 0", rx_busy); end
    wait_ticks(160);
    vectors++;
    if (done_count - d0 !== 0) begin miscompares++; $display("[TB] FAIL glitch_count: got %0d, required 0", done_count - d0); end
    vectors++;
    if (rx_data !== old) begin miscompares++; $display("[TB] FAIL glitch_data: got %h, required %h", rx_data, old); end
  endtask

  task automatic test_frame_err();
    sb.push_back({8'hC3, 1'b1});
    applyStimulus(8'hC3, 12, -1);
    wait_ticks(16);
    drain("ferr");
    vectors++;
    if (rx_frame_err !== 1'b1) begin miscompares++; $display("[TB] FAIL ferr_flag: got %b, required 1", rx_frame_err); end
    vectors++;
    if (rx_data !== 8'hC3) begin miscompares++; $display("[TB] FAIL ferr_data: got %h, required c3", rx_data); end
    sb.push_back({8'h01, 1'b0});
    applyStimulus(8'h01, 0, -1);
    drain("ferr_clear");
    vectors++;
    if (rx_frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL ferr_clear: got %b, required 0", rx_frame_err); end
    vectors++;
    if (rx_data !== 8'h01) begin miscompares++; $display("[TB] FAIL ferr_next_data: got %h, required 01", rx_data); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_count;
    sb.push_back({8'hA3, 1'b0});
    applyStimulus(8'hA3, 0, -1);
    sb.push_back({8'h0F, 1'b0});
    applyStimulus(8'h0F, 0, -1);
    drain("b2b");
    vectors++;
    if (done_count - d0 !== 2) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d, required 2", done_count - d0); end
    vectors++;
    if (rx_data !== 8'h0F) begin miscompares++; $display("[TB] FAIL b2b_last: got %h, required 0f", rx_data); end
  endtask

  task automatic test_reset_midframe();
    int d0 = done_count;
    applyStimulus(8'h7E, 0, 4);
    vectors++;
    if (done_count - d0 !== 0) begin miscompares++; $display("[TB] FAIL abort_count: got %0d, required 0", done_count - d0); end
    vectors++;
    if (rx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL abort_data: got %h, required 00", rx_data); end
    vectors++;
    if (rx_frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_err: got %b, required 0", rx_frame_err); end
    vectors++;
    if (rx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b, required 0", rx_busy); end
    d0 = done_count;
    sb.push_back({8'h12, 1'b0});
    applyStimulus(8'h12, 0, -1);
    drain("abort_next");
    vectors++;
    if (done_count - d0 !== 1) begin miscompares++; $display("[TB] FAIL abort_next_count: got %0d, required 1", done_count - d0); end
    vectors++;
    if (rx_data !== 8'h12) begin miscompares++; $display("[TB] FAIL abort_next_data: got %h, required 12", rx_data); end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h5A};
    int d0 = done_count;
    int n;
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back({bytes[i], 1'b0});
      tx_data = bytes[i];
      tx_req = 1'b1;
      n = 0;
      while (tx_req && n < 4000) begin
        @(negedge clk);
        n++;
      end
      vectors++;
      if (tx_req !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL loop_tx_timeout: got busy transmitter, required idle");
        tx_req = 1'b0;
      end
    end
    drain("loop");
    vectors++;
    if (done_count - d0 !== 3) begin miscompares++; $display("[TB] FAIL loop_count: got %0d, required 3", done_count - d0); end
    vectors++;
    if (rx_frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL loop_err: got %b, required 0", rx_frame_err); end
    loop_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_loopback();
    wait_ticks(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
